// File: rtl/csr_mon_pkg.sv
// Shared definitions for the CSR debug-monitor access path: command op codes,
// sequencer states, well-known machine CSR addresses and the write-value helper.
// Optional macro CSR_MON_VERIFY_EN adds the post-write readback state.
package csr_mon_pkg;

  typedef enum logic [1:0] {
    CSRMON_RD  = 2'b00,
    CSRMON_WR  = 2'b01,
    CSRMON_SET = 2'b10,
    CSRMON_CLR = 2'b11
  } csrmon_op_e;

`ifdef CSR_MON_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAITH = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4,
    ST_VFY   = 3'd5
  } csrmon_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAITH = 3'd1,
    ST_RD    = 3'd2,
    ST_WR    = 3'd3,
    ST_RESP  = 3'd4
  } csrmon_state_e;
`endif

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;

  // Value to drive on the monitor write port for a given op.
  function automatic logic [31:0] csrmon_wval(input csrmon_op_e op,
                                              input logic [31:0] rd,
                                              input logic [31:0] wd);
    logic [31:0] v;
    case (op)
      CSRMON_SET: v = rd | wd;
      CSRMON_CLR: v = rd & ~wd;
      default:    v = wd;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/csr_mon_access_if.sv
// Command/response channel between the debug monitor command decoder (master)
// and the CSR monitor access sequencer (slave).
interface csr_mon_access_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_adr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_adr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/csr_mon_access.sv
// Debug-monitor initiator for the CSR array: takes one read/write/set/clear
// command at a time, waits for the CPU to halt, sequences the monitor read and
// write strobes and returns a single response.
// Optional macro CSR_MON_VERIFY_EN: read back after every write and flag a
// mismatch as an error.
module csr_mon_access
  import csr_mon_pkg::*;
#(
  parameter int unsigned HALT_TO = 1024,
  parameter int unsigned TO_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  csr_mon_access_if.slave   mon,
  input  logic              cpu_halted,
  output logic              csr_radr_en_mon,
  output logic [11:0]       csr_radr_mon,
  output logic [11:0]       csr_wadr_mon,
  output logic              csr_we_mon,
  output logic [31:0]       csr_wdata_mon,
  input  logic [31:0]       csr_rdata_mon
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TO - 1);

  csrmon_state_e   state_q, state_d;
  csrmon_op_e      op_q, op_d;
  logic [11:0]     adr_q, adr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdreg_q, rdreg_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     wval;

  assign wval = csrmon_wval(op_q, rdreg_q, wdata_q);

  // State and datapath registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= CSRMON_RD;
      adr_q      <= '0;
      wdata_q    <= '0;
      rdreg_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdreg_q    <= rdreg_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state, datapath updates and strobe/handshake outputs.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdreg_d    = rdreg_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;

    mon.cmd_ready   = 1'b0;
    mon.rsp_valid   = 1'b0;
    mon.rsp_data    = '0;
    mon.rsp_err     = 1'b0;
    csr_radr_en_mon = 1'b0;
    csr_radr_mon    = '0;
    csr_we_mon      = 1'b0;
    csr_wadr_mon    = '0;
    csr_wdata_mon   = '0;

    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so cmd_ready reads 0 while reset is held.
        mon.cmd_ready = rst_n;
        if (mon.cmd_valid) begin
          op_d       = csrmon_op_e'(mon.cmd_op);
          adr_d      = mon.cmd_adr;
          wdata_d    = mon.cmd_wdata;
          cnt_d      = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ST_WAITH;
        end
      end

      ST_WAITH: begin
        if (cpu_halted) begin
          state_d = (op_q == CSRMON_WR) ? ST_WR : ST_RD;
        end else if ((HALT_TO != 0) && (cnt_q == TO_LAST)) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RD: begin
        csr_radr_en_mon = 1'b1;
        csr_radr_mon    = adr_q;
        rdreg_d         = csr_rdata_mon;
        if (op_q == CSRMON_RD) begin
          rsp_data_d = csr_rdata_mon;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        csr_we_mon    = 1'b1;
        csr_wadr_mon  = adr_q;
        csr_wdata_mon = wval;
        rsp_data_d    = (op_q == CSRMON_WR) ? 32'h0 : rdreg_q;
`ifdef CSR_MON_VERIFY_EN
        state_d = ST_VFY;
`else
        state_d = ST_RESP;
`endif
      end

`ifdef CSR_MON_VERIFY_EN
      // wval is still valid here: rdreg_q and wdata_q are unchanged since WR.
      ST_VFY: begin
        csr_radr_en_mon = 1'b1;
        csr_radr_mon    = adr_q;
        if (csr_rdata_mon != wval) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = csr_rdata_mon;
        end
        state_d = ST_RESP;
      end
`endif

      ST_RESP: begin
        mon.rsp_valid = 1'b1;
        mon.rsp_data  = rsp_data_q;
        mon.rsp_err   = rsp_err_q;
        if (mon.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
